// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer placed directly after the UART receiver. Each completed
// frame shows up as a one-cycle rx_done_tick together with a byte on din. The
// bytes are held in a first-word-fall-through FIFO until the host pops them.
// The block reports occupancy and keeps a sticky overrun flag for bytes that
// had to be dropped because the FIFO was full and nothing was being read.
//
// Parameters
//   DWIDTH        data byte width (matches the receiver's data output)
//   AWIDTH        address bits; depth is 2**AWIDTH entries
//
// Ports
//   clk           system clock, all registers update on the rising edge
//   reset         asynchronous, active-high reset
//   rx_done_tick  one-cycle pulse: the byte on din is complete
//   din           received byte, only looked at while rx_done_tick is high
//   rd_uart       pop request from the consumer, ignored while rx_empty
//   clr_overrun   synchronous clear of the overrun flag
//   dout          head entry (oldest byte), meaningful only while !rx_empty
//   rx_empty      FIFO holds no entries
//   rx_full       FIFO holds 2**AWIDTH entries
//   count         number of stored entries, 0 .. 2**AWIDTH
//   overrun       sticky: a byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [DWIDTH-1:0] din,
  input  logic              rd_uart,
  input  logic              clr_overrun,
  output logic [DWIDTH-1:0] dout,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [AWIDTH:0]   count,
  output logic              overrun
);

  localparam int unsigned      DEPTH      = 1 << AWIDTH;
  localparam logic [AWIDTH:0]  FULL_COUNT = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0]  COUNT_ONE  = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);

  // Storage array; deliberately not reset so it maps onto plain registers
  // or distributed RAM. Contents after reset are stale but unreachable.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_q;
  logic              overrun_q;

  logic we;
  logic re;
  logic drop;

  // Flags come straight from the registered count so they never see a
  // combinational path from the inputs. Using count rather than pointer
  // equality removes the usual full/empty ambiguity when the pointers meet.
  assign rx_empty = (count_q == '0);
  assign rx_full  = (count_q == FULL_COUNT);

  // A write is accepted when there is room, or when a pop in the same cycle
  // frees the head slot. At full with a simultaneous pop, wr_ptr equals
  // rd_ptr, so the new byte lands exactly in the slot being vacated.
  assign we   = rx_done_tick & (~rx_full | rd_uart);
  assign re   = rd_uart & ~rx_empty;
  assign drop = rx_done_tick & rx_full & ~rd_uart;

  // Write port of the storage array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally through their AWIDTH-bit width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (re) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      unique case ({we, re})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overrun. A new drop in the same cycle as a clear keeps the flag
  // set so that the host cannot lose the evidence of that dropped byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  // First-word fall-through: the head entry is always on dout.
  assign dout    = mem[rd_ptr];
  assign count   = count_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed self-checking bench for uart_rx_fifo with the default 8-bit data
// and 16-entry depth. Inputs are driven 1 ns after a rising edge and held for
// one full cycle; outputs are sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DWIDTH = 8;
  localparam int AWIDTH = 4;
  localparam int DEPTH  = 1 << AWIDTH;

  logic              clk;
  logic              reset;
  logic              rx_done_tick;
  logic [DWIDTH-1:0] din;
  logic              rd_uart;
  logic              clr_overrun;
  logic [DWIDTH-1:0] dout;
  logic              rx_empty;
  logic              rx_full;
  logic [AWIDTH:0]   count;
  logic              overrun;

  int checks;
  int errors;

  uart_rx_fifo #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .din         (din),
    .rd_uart     (rd_uart),
    .clr_overrun (clr_overrun),
    .dout        (dout),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .count       (count),
    .overrun     (overrun)
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, then return the
  // inputs to idle and leave time at edge+1ns for sampling.
  task automatic applyStimulus(input logic done, input logic [DWIDTH-1:0] data,
                               input logic rd, input logic clr);
    rx_done_tick = done;
    din          = data;
    rd_uart      = rd;
    clr_overrun  = clr;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rd_uart      = 1'b0;
    clr_overrun  = 1'b0;
  endtask

  task automatic writeByte(input logic [DWIDTH-1:0] data);
    applyStimulus(1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Writes 0x00..0x0F into an empty FIFO.
  task automatic fillIncrementing();
    for (int i = 0; i < DEPTH; i++) begin
      writeByte(DWIDTH'(i));
    end
  endtask

  // Checks the head against the expected byte, then pops it.
  task automatic checkAndPop(input string tag, input logic [DWIDTH-1:0] expected);
    checkOutput(tag, 32'(dout), 32'(expected));
    popByte();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    din          = '0;
    rd_uart      = 1'b0;
    clr_overrun  = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_empty",   32'(rx_empty), 32'd1);
    checkOutput("reset_full",    32'(rx_full),  32'd0);
    checkOutput("reset_count",   32'(count),    32'd0);
    checkOutput("reset_overrun", 32'(overrun),  32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single byte in, single byte out.
    writeByte(8'hA5);
    checkOutput("a5_empty", 32'(rx_empty), 32'd0);
    checkOutput("a5_dout",  32'(dout),     32'hA5);
    checkOutput("a5_count", 32'(count),    32'd1);
    popByte();
    checkOutput("a5_pop_empty", 32'(rx_empty), 32'd1);
    checkOutput("a5_pop_count", 32'(count),    32'd0);

    // Fill to 16 then drain in order.
    fillIncrementing();
    checkOutput("fill_full",  32'(rx_full), 32'd1);
    checkOutput("fill_count", 32'(count),   32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      checkAndPop("drain_dout", DWIDTH'(i));
    end
    checkOutput("drain_empty", 32'(rx_empty), 32'd1);
    checkOutput("drain_full",  32'(rx_full),  32'd0);

    // Overrun: write while full without a read drops the byte.
    fillIncrementing();
    writeByte(8'h55);
    checkOutput("ovr_flag",  32'(overrun), 32'd1);
    checkOutput("ovr_count", 32'(count),   32'd16);
    // Another drop together with a clear: the set wins.
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b1);
    checkOutput("ovr_set_wins", 32'(overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      checkAndPop("ovr_drain_dout", DWIDTH'(i));
    end
    checkOutput("ovr_drain_empty", 32'(rx_empty), 32'd1);
    checkOutput("ovr_still_set",   32'(overrun),  32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("ovr_cleared", 32'(overrun), 32'd0);

    // Full with write and read together: head pops, new byte takes the slot.
    fillIncrementing();
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("pass_count",   32'(count),   32'd16);
    checkOutput("pass_full",    32'(rx_full), 32'd1);
    checkOutput("pass_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      checkAndPop("pass_drain_dout", DWIDTH'(i));
    end
    checkAndPop("pass_last_dout", 8'h77);
    checkOutput("pass_empty", 32'(rx_empty), 32'd1);

    // Pointer wrap through 40 write/read pairs.
    for (int i = 0; i < 40; i++) begin
      writeByte(DWIDTH'(8'h80 + i));
      checkOutput("wrap_count", 32'(count), 32'd1);
      checkAndPop("wrap_dout", DWIDTH'(8'h80 + i));
    end
    checkOutput("wrap_empty", 32'(rx_empty), 32'd1);

    // Empty with write and read together: read ignored, write happens.
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    checkOutput("empty_wr_rd_count", 32'(count),    32'd1);
    checkOutput("empty_wr_rd_dout",  32'(dout),     32'h3C);
    checkOutput("empty_wr_rd_empty", 32'(rx_empty), 32'd0);
    popByte();

    // Asynchronous reset with 5 entries held and overrun set.
    fillIncrementing();
    writeByte(8'hEE);
    for (int i = 0; i < DEPTH - 5; i++) begin
      popByte();
    end
    checkOutput("pre_reset_count",   32'(count),   32'd5);
    checkOutput("pre_reset_overrun", 32'(overrun), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_empty",   32'(rx_empty), 32'd1);
    checkOutput("async_reset_count",   32'(count),    32'd0);
    checkOutput("async_reset_overrun", 32'(overrun),  32'd0);
    checkOutput("async_reset_full",    32'(rx_full),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    writeByte(8'h9E);
    checkOutput("post_reset_dout",  32'(dout),  32'h9E);
    checkOutput("post_reset_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
